// File: rtl/synth_sequencer.sv
// synth_sequencer: timed note-event bus initiator.
// Events (addr, data, delay) are queued in a small FIFO. Each one waits
// `delay` ticks and is then written once on the voice-register bus. The
// write is held until the responder acknowledges it.
// Optional build macro SYNTH_SEQ_TIMEOUT_EN adds a write-acknowledge
// watchdog (TIMEOUT cycles) and a sticky err flag. Without the macro, a
// write waits indefinitely and err is tied low.
module synth_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TICK_DIV   = 8000
`ifdef SYNTH_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          evt_valid,
  output logic                          evt_ready,
  input  logic [3:0]                    evt_addr,
  input  logic [31:0]                   evt_data,
  input  logic [7:0]                    evt_delay,
  output logic [3:0]                    addr,
  output logic [31:0]                   data_out,
  output logic                          wen,
  output logic                          ren,
  input  logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [7:0]  delay;
  } evt_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    WRITE
  } state_t;

  state_t        state, state_next;
  evt_t          mem [FIFO_DEPTH];
  evt_t          head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          empty, full, push, pop;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    remaining;
  logic          to_expire;

  // ---------------- event FIFO ----------------
  assign level     = wr_ptr - rd_ptr;
  assign empty     = (level == '0);
  assign full      = (level == LW'(FIFO_DEPTH));
  assign evt_ready = !full && !rst;
  assign push      = evt_valid && evt_ready;
  // Pops read only registered occupancy, so an event always spends at least one cycle queued.
  assign pop       = (state == IDLE) && enable && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Event storage: written on push only.
  // NOTE: the storage array is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{addr: evt_addr, data: evt_data, delay: evt_delay};
  end

  // Read/write pointers with one wrap bit so full and empty are distinguishable.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------- tick generator ----------------
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running divider, independent of enable and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------- optional write watchdog ----------------
`ifdef SYNTH_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // The acknowledge wins if it arrives in the last allowed cycle.
  assign to_expire = (state == WRITE) && !ready && (to_cnt == CW'(TIMEOUT - 1));

  // Counts WRITE cycles and latches err when an acknowledge never arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != WRITE) to_cnt <= '0;
      else                to_cnt <= to_cnt + CW'(1);
      if (to_expire) err <= 1'b1;
    end
  end
`else
  assign to_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // ---------------- sequencing FSM ----------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and bus strobe.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    wen        = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) state_next = (head.delay == 8'd0) ? WRITE : DELAY;
      end
      DELAY: begin
        if (tick && enable && remaining == 8'd1) state_next = WRITE;
      end
      WRITE: begin
        wen = 1'b1;
        if (ready || to_expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding registers: bus address/data keep their last values; only wen qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      data_out  <= '0;
      remaining <= '0;
    end else if (pop) begin
      addr      <= head.addr;
      data_out  <= head.data;
      remaining <= head.delay;
    end else if (state == DELAY && tick && enable) begin
      remaining <= remaining - 8'd1;
    end
  end

  assign ren        = 1'b0;
  assign busy       = (state != IDLE) || !empty;
  assign fifo_level = level;

endmodule

// File: tb/tb_synth_sequencer.sv
// Bench for synth_sequencer: scoreboard of expected writes (address, data,
// wen length) fed at push time, a separate bus monitor that checks every
// write, a responder that acknowledges with per-event latency, and a
// randomized phase after the directed scenarios.
module tb_synth_sequencer;

  localparam int DEPTH = 16;
  localparam int TDIV  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int STUCK = 255;
`ifdef SYNTH_SEQ_TIMEOUT_EN
  localparam int TO    = 64;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic [3:0]    evt_addr = '0;
  logic [31:0]   evt_data = '0;
  logic [7:0]    evt_delay = '0;
  logic [3:0]    addr;
  logic [31:0]   data_out;
  logic          wen, ren;
  logic          ready = 1'b0;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          err;

  synth_sequencer #(
    .FIFO_DEPTH(DEPTH),
    .TICK_DIV  (TDIV)
`ifdef SYNTH_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT   (TO)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_addr  (evt_addr),
    .evt_data  (evt_data),
    .evt_delay (evt_delay),
    .addr      (addr),
    .data_out  (data_out),
    .wen       (wen),
    .ren       (ren),
    .ready     (ready),
    .busy      (busy),
    .fifo_level(fifo_level),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          len;
  } exp_t;

  exp_t sb_q[$];
  int   rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected number of cycles wen stays high for a given responder latency.
  function automatic int exp_len(input int lat);
`ifdef SYNTH_SEQ_TIMEOUT_EN
    if (lat == STUCK || lat + 1 > TO) return TO;
    return lat + 1;
`else
    return lat + 1;
`endif
  endfunction

  // Cycle index since reset release; equals the DUT tick divider phase model.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Responder: raises ready after the event's latency in wen-high cycles.
  int hi_cnt  = 0;
  int cur_lat = 0;
  always @(negedge clk) begin
    if (rst) begin
      hi_cnt = 0;
      ready  = 1'b0;
    end else if (wen) begin
      if (hi_cnt == 0) cur_lat = (rsp_q.size() > 0) ? rsp_q.pop_front() : 0;
      hi_cnt++;
      ready = (cur_lat != STUCK) && (hi_cnt > cur_lat);
    end else begin
      hi_cnt = 0;
      ready  = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each write and checks content, stability and length.
  logic        prev_wen = 1'b0;
  int          wlen = 0;
  exp_t        cur_exp;
  logic [3:0]  hold_addr;
  logic [31:0] hold_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_wen = 1'b0;
      wlen     = 0;
    end else begin
      if (wen && !prev_wen) begin
        n_writes++;
        wlen = 1;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          cur_exp.len = 0;
          $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", addr, data_out);
        end else begin
          cur_exp = sb_q.pop_front();
          check("write_addr", addr, cur_exp.addr);
          check("write_data", data_out, cur_exp.data);
        end
        hold_addr = addr;
        hold_data = data_out;
      end else if (wen) begin
        wlen++;
        check("bus_stable", {addr, data_out}, {hold_addr, hold_data});
      end else if (prev_wen) begin
        check("wen_length", wlen, cur_exp.len);
      end
      prev_wen = wen;
    end
  end

  // Drives one event for one cycle; records the expected write if it should be accepted.
  task automatic push_evt(input logic [3:0] a, input logic [31:0] d, input logic [7:0] dl,
                          input int lat, input bit accept);
    evt_addr  = a;
    evt_data  = d;
    evt_delay = dl;
    evt_valid = 1'b1;
    check("evt_ready_at_push", evt_ready, accept);
    if (accept) begin
      sb_q.push_back('{addr: a, data: d, len: exp_len(lat)});
      rsp_q.push_back(lat);
    end
    @(negedge clk);
    evt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((busy || wen) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, busy || wen, 1'b0);
  endtask

  task automatic wait_wen(input string name, input int max);
    int n = 0;
    while (!wen && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, wen, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, start, t1, e_rise;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_evt_ready", evt_ready, 1'b0);
    check("rst_wen", wen, 1'b0);
    check("rst_ren", ren, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_bus", {addr, data_out}, 0);
    rst = 1'b0;
    #1;
    check("evt_ready_after_rst", evt_ready, 1'b1);
    @(negedge clk);

    // ---- single write latency ----
    enable = 1'b1;
    n0 = n_writes;
    push_evt(4'd2, 32'd1, 8'd0, 1, 1'b1);
    check("lat_n1_wen", wen, 1'b0);
    check("lat_n1_level", fifo_level, 1);
    @(negedge clk);
    check("lat_n2_wen", wen, 1'b1);
    check("lat_n2_addr", addr, 4'd2);
    check("lat_n2_data", data_out, 32'd1);
    @(negedge clk);
    check("lat_n3_wen", wen, 1'b1);
    @(negedge clk);
    check("lat_n4_wen", wen, 1'b0);
    wait_idle("single_idle", 20);
    check("single_write_count", n_writes - n0, 1);

    // ---- tick delay ----
    start = cyc;
    push_evt(4'd7, 32'hCAFE_0001, 8'd3, 0, 1'b1);
    t1 = start + 2;
    while (t1 % TDIV != TDIV - 1) t1++;
    e_rise = t1 + 2 * TDIV + 1;
    wait_wen("tick_wen_seen", 100);
    check("tick_delay_rise_cycle", cyc, e_rise);
    wait_idle("tick_idle", 20);

    // ---- fill while paused, overflow, then drain ----
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_evt(4'(i), $urandom, 8'd0, $urandom_range(0, 2), 1'b1);
    check("full_level", fifo_level, DEPTH);
    check("full_busy", busy, 1'b1);
    push_evt(4'hF, 32'hDEAD_BEEF, 8'd0, 0, 1'b0);
    check("overflow_level", fifo_level, DEPTH);
    check("paused_no_write", wen, 1'b0);
    n0 = n_writes;
    enable = 1'b1;
    wait_idle("drain_idle", 500);
    check("drain_write_count", n_writes - n0, DEPTH);
    check("drain_sb_empty", sb_q.size(), 0);

    // ---- responder stall ----
    push_evt(4'd5, 32'hA5A5_0001, 8'd0, 10, 1'b1);
    push_evt(4'd6, 32'h0000_0102, 8'd0, 0, 1'b1);
    wait_wen("stall_wen_seen", 10);
    for (int i = 0; i < 5; i++) begin
      check("stall_level", fifo_level, 1);
      check("stall_wen", wen, 1'b1);
      @(negedge clk);
    end
    wait_idle("stall_idle", 60);

    // ---- reset during DELAY ----
    for (int i = 0; i < 4; i++) push_evt(4'(8 + i), $urandom, 8'd5, 0, 1'b1);
    check("delay_level", fifo_level, 3);
    check("delay_wen", wen, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_delay_wen", wen, 1'b0);
    check("rst_delay_level", fifo_level, 0);
    check("rst_delay_busy", busy, 1'b0);
    sb_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_delay_evt_ready", evt_ready, 1'b1);
    n0 = n_writes;
    repeat (60) @(negedge clk);
    check("rst_delay_no_write", n_writes - n0, 0);

    // ---- reset during WRITE ----
    push_evt(4'd9, 32'h1234_5679, 8'd0, STUCK, 1'b1);
    wait_wen("rstw_wen_seen", 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_write_wen", wen, 1'b0);
    check("rst_write_addr", addr, 4'd0);
    sb_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef SYNTH_SEQ_TIMEOUT_EN
    // ---- acknowledge timeout ----
    n0 = n_writes;
    push_evt(4'd3, 32'h0BAD_0003, 8'd0, STUCK, 1'b1);
    push_evt(4'd4, 32'h600D_0004, 8'd0, 0, 1'b1);
    wait_idle("timeout_idle", 300);
    check("timeout_err", err, 1'b1);
    check("timeout_write_count", n_writes - n0, 2);
`endif

    // ---- randomized traffic ----
    n0 = n_writes;
    start = 0;
    for (int i = 0; i < 60; i++) begin
      enable = ($urandom_range(0, 9) < 8);
      if (sb_q.size() < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
        push_evt(4'($urandom), $urandom, 8'($urandom_range(0, 2)), $urandom_range(0, 3), 1'b1);
        start++;
      end else begin
        @(negedge clk);
      end
    end
    enable = 1'b1;
    wait_idle("random_idle", 2000);
    check("random_sb_empty", sb_q.size(), 0);
    check("random_write_count", n_writes - n0, start);
`ifdef SYNTH_SEQ_TIMEOUT_EN
    check("final_err", err, 1'b1);
`else
    check("final_err", err, 1'b0);
`endif
    check("final_ren", ren, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_sequencer.md
Name: synth_sequencer

Overview:
Bus initiator that drives the synth voice-register port (addr/data/wen/ren/ready) from a queue of timed note events. Firmware or a DMA engine pushes events into a small FIFO. Each event waits its delay in ticks, then issues one register write and holds it until the responder acknowledges. This offloads note timing from the CPU and sits between the event source and the synth interface.

Parameters:
FIFO_DEPTH, 16, event FIFO entries; must be a power of two and at least 2.
TICK_DIV, 8000, clk cycles per tick (1 ms at 8 MHz).
TIMEOUT, 64, clk cycles allowed for the write acknowledge (optional feature only).

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
enable  in  1  1 = run; 0 = pause popping and delay countdown.
evt_valid  in  1  event push request.
evt_ready  out  1  FIFO can accept; equals !full, forced 0 while rst is high.
evt_addr  in  4  target voice register.
evt_data  in  32  write data; bit0 = gate.
evt_delay  in  8  ticks to wait before the write; 0 = no wait.
addr  out  4  bus address.
data_out  out  32  bus write data.
wen  out  1  bus write strobe.
ren  out  1  bus read strobe; always 0.
ready  in  1  bus acknowledge from the responder.
busy  out  1  (state != IDLE) || FIFO not empty.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
err  out  1  sticky timeout flag.

Behaviour:
- Reset (async): FIFO empty; state IDLE; tick counter 0; addr, data_out, wen, ren, busy, fifo_level, err all 0.
- FIFO:
  - Push occurs when evt_valid && evt_ready.
  - Pop occurs only from IDLE, only when the FIFO is not empty.
  - Push and pop in the same cycle: level unchanged.
  - Full: evt_ready = 0 and the push is ignored.
  - No bypass: an event spends at least one cycle in the FIFO.
- Tick generator: free-running counter 0..TICK_DIV-1, unaffected by state or enable. The tick pulse fires for one cycle when the count equals TICK_DIV-1, then the counter wraps to 0.
- FSM:
  - IDLE: if enable && !empty, pop the head into holding registers (addr, data, remaining = delay). Next state is WRITE if delay == 0, else DELAY.
  - DELAY: on each tick with enable high, remaining decrements. On a tick where remaining == 1, go to WRITE. With enable low the countdown freezes and the state holds.
  - WRITE:
    - wen = 1; addr and data_out are driven from the holding registers and stay stable.
    - The write completes on a cycle where ready is sampled 1.
    - wen deasserts on the next cycle and the FSM returns to IDLE.
    - enable low does not abort an in-progress WRITE.
- addr and data_out retain their last values outside WRITE. Only wen qualifies them.
- Latency: event pushed in cycle N into an empty FIFO with delay 0 and enable high → pop in N+1, wen = 1 in N+2.
- Back-to-back: after a write completes, IDLE may pop the next event one cycle later. Consecutive wen pulses are therefore separated by at least 1 low cycle.
- Reset mid-operation: wen drops immediately. The pending event and all FIFO contents are discarded.

Optional Feature:
SYNTH_SEQ_TIMEOUT_EN:
- Defined: a cycle counter starts on WRITE entry. If ready has not been sampled 1 after TIMEOUT cycles, wen deasserts, err is set to 1 and the FSM returns to IDLE; the event is dropped. err is cleared only by rst.
- Undefined: the counter is absent, WRITE waits indefinitely, and err is tied to 0.

Test Plan:
- Push addr=2, data=1, delay=0 in cycle N; responder raises ready 1 cycle after wen → wen=1 in N+2 with addr=2 and data_out=1; wen=0 two cycles later; exactly one write; busy returns to 0.
- TICK_DIV=4, push delay=3 → wen rises the cycle after the 3rd tick pulse following the pop; no write before that.
- enable=0, push 16 events (addr 0..15) → fifo_level=16, evt_ready=0, 17th push ignored. Set enable=1 → 16 writes in addr order 0..15, each with a wen gap of at least 1 cycle.
- Responder holds ready=0 for 10 cycles → wen stays 1 with addr/data stable, no pop, fifo_level unchanged; write completes on cycle 11.
- Assert rst during DELAY with 3 events queued → wen=0 and fifo_level=0 immediately; after release evt_ready=1 and no write occurs.
- With SYNTH_SEQ_TIMEOUT_EN and TIMEOUT=64, ready tied 0 → wen drops after 64 cycles, err=1, next queued event still issues its write.
